flap_input_ctrl: RTL and testbench

Front-end input stage of the bird datapath: turns the raw flap push-button into a clean, single "flap request" per press, and generates the game-rate `tick` strobe that paces bird-row updates. `tick` drives the bird LED blocks' update-select, and `flap` drives their `in`. Each `flap` is therefore guaranteed to be held until the next `tick` consumes it, so no tap is lost between slow game steps.

---
 rtl/flap_input_ctrl.sv | 129 ++++++++++++
 tb/tb_flap_input_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flap_input_ctrl.sv
// flap_input_ctrl
//   Front end of the bird datapath. It turns the raw, bouncy, asynchronous
//   flap push-button into one clean flap request per press. It also generates
//   the game-rate tick strobe that paces bird-row updates. A request is held
//   until the next tick consumes it, so taps between slow game steps are kept.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a new synchronized level must persist (>= 2)
//   TICK_W          : prescaler width; tick period is 2**TICK_W cycles
//
// Ports
//   clk        in   system clock, single domain
//   reset      in   synchronous, active-high (also pulsed after each point)
//   key_n      in   raw push-button, active-low, asynchronous to clk
//   startGame  in   game-running enable; 0 freezes pacing and drops presses
//   tick       out  one-cycle game-step strobe
//   flap       out  pending flap request (level, registered)
//   pressed    out  debounced button level, 1 = held
//
// Build option
//   FLAP_AUTOREPEAT_EN : when defined, a held button requests a flap on every
//                        tick instead of once per press.
module flap_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic startGame,
  output logic tick,
  output logic flap,
  output logic pressed
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1_r;
  logic              sync2_r;
  logic              db_r;
  logic              db_q_r;
  logic [DCNT_W-1:0] dcnt_r;
  logic [TICK_W-1:0] tcnt_r;
  logic              flap_r;

  logic              press_evt_s;
  logic              request_s;
  logic              tick_s;
  logic              flap_next_s;

  // Two-flop synchronizer on the inverted (active-high) button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: accept a new level only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to db restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r   <= 1'b0;
      dcnt_r <= {DCNT_W{1'b0}};
    end else if (sync2_r == db_r) begin
      db_r   <= db_r;
      dcnt_r <= {DCNT_W{1'b0}};
    end else if (dcnt_r == DCNT_MAX) begin
      db_r   <= sync2_r;
      dcnt_r <= {DCNT_W{1'b0}};
    end else begin
      db_r   <= db_r;
      dcnt_r <= dcnt_r + DCNT_W'(1'b1);
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q_r <= 1'b0;
    end else begin
      db_q_r <= db_r;
    end
  end

  // Game-rate prescaler; held at zero while the game is stopped so the
  // first tick always lands a full period minus one after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_r <= {TICK_W{1'b0}};
    end else if (startGame) begin
      tcnt_r <= tcnt_r + TICK_W'(1'b1);
    end else begin
      tcnt_r <= {TICK_W{1'b0}};
    end
  end

  // Press detection, tick decode and next value of the pending request.
  always_comb begin
    press_evt_s = db_r & ~db_q_r;
`ifdef FLAP_AUTOREPEAT_EN
    request_s   = press_evt_s | db_r;
`else
    request_s   = press_evt_s;
`endif
    tick_s      = startGame & (&tcnt_r);
    // A tick consumes the current request; a press in that same cycle
    // re-arms it for the following window.
    flap_next_s = startGame & (request_s | (flap_r & ~tick_s));
  end

  // Pending flap request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      flap_r <= 1'b0;
    end else begin
      flap_r <= flap_next_s;
    end
  end

  assign tick    = tick_s;
  assign flap    = flap_r;
  assign pressed = db_r;

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Self-checking bench for flap_input_ctrl: directed scenarios followed by
// randomized button/enable/reset activity, all checked every cycle against a
// behavioural model built from the block's rules (sample-window debounce,
// cycle-count-since-start pacing, pending-request flag).
module tb_flap_input_ctrl;

  localparam int D  = 4;
  localparam int TW = 5;
  localparam int P  = 1 << TW;
`ifdef FLAP_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic startGame = 1'b0;
  logic tick;
  logic flap;
  logic pressed;

  always #5 clk = ~clk;

  flap_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_W(TW)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .startGame(startGame),
    .tick(tick), .flap(flap), .pressed(pressed)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_s1, m_s2, m_db, m_dbq, m_flap;
  bit hist[$];          // most recent synchronized samples, at most D
  int m_run;            // consecutive edges that sampled startGame=1

  logic o_tick, o_flap, o_pressed;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_dbq = 1'b0; m_flap = 1'b0;
    hist.delete();
    m_run = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model at posedge.
  task automatic cyc(input logic k, input logic sg, input logic rst);
    bit te, pe, all_diff, dbn, fn;
    @(negedge clk);
    key_n = k; startGame = sg; reset = rst;
    #1;
    te = sg && ((m_run % P) == P - 1);
    o_tick = tick; o_flap = flap; o_pressed = pressed;
    chk_bit("tick", tick, te);
    chk_bit("flap", flap, m_flap);
    chk_bit("pressed", pressed, m_db);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pe = m_db && !m_dbq;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      all_diff = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
      dbn = all_diff ? !m_db : m_db;
      fn = sg && (pe || (AUTO && m_db) || (m_flap && !te));
      m_dbq = m_db; m_db = dbn; m_flap = fn;
      m_run = sg ? m_run + 1 : 0;
      m_s2 = m_s1; m_s1 = !k;
    end
  endtask

  initial begin
    int p_first, f_first, t_first, nt, nf, exp_t, rises;
    bit got, prev_f;
    logic kv, sgv;
    int hold;

    // Reset with button held and game enabled
    reset = 1'b1; key_n = 1'b0; startGame = 1'b1;
    @(posedge clk);
    model_reset();
    repeat (3) cyc(1'b0, 1'b1, 1'b1);

    // Button held through reset: pressed at 2+D edges, flap one later
    p_first = -1; f_first = -1;
    for (int e = 0; e < 40; e++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (o_pressed && p_first < 0) p_first = e;
      if (o_flap && f_first < 0) f_first = e;
    end
    chk_int("reset_pressed_latency", p_first, 2 + D);
    chk_int("reset_flap_latency", f_first, 3 + D);
    repeat (2 * P) cyc(1'b1, 1'b1, 1'b0);

    // Tick period and forced restart when startGame drops
    exp_t = 0;
    for (int k = 0; k < 80; k++) if ((k % P) == P - 1) exp_t++;
    for (int rep = 0; rep < 2; rep++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk_bit("tick_when_stopped", o_tick, 1'b0);
      nt = 0; t_first = -1;
      for (int k = 0; k < 80; k++) begin
        cyc(1'b1, 1'b1, 1'b0);
        if (o_tick) begin
          nt++;
          if (t_first < 0) t_first = k;
        end
      end
      chk_int("tick_first", t_first, P - 1);
      chk_int("tick_count", nt, exp_t);
    end

    // Glitch shorter than D is ignored
    repeat (2 * P) cyc(1'b1, 1'b1, 1'b0);
    nt = 0; nf = 0;
    for (int k = 0; k < 4 * D; k++) begin
      cyc((k < D - 1) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (o_pressed) nt++;
      if (o_flap) nf++;
    end
    chk_int("glitch_pressed", nt, 0);
    chk_int("glitch_flap", nf, 0);

    // Valid press: latency from first sampled low level
    p_first = -1; f_first = -1;
    for (int k = 0; k < D + 12; k++) begin
      cyc((k < D + 2) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (o_pressed && p_first < 0) p_first = k;
      if (o_flap && f_first < 0) f_first = k;
    end
    chk_int("press_pressed_latency", p_first, 2 + D);
    chk_int("press_flap_latency", f_first, 3 + D);

    // Three presses inside one window coalesce into one request
    repeat (2 * P) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    nf = 0; rises = 0; prev_f = 1'b0;
    for (int k = 0; k < 3 * P; k++) begin
      cyc(((k < 30) && ((k % 10) < 5)) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (o_flap && !prev_f) rises++;
      if (o_tick && o_flap) nf++;
      prev_f = o_flap;
    end
    chk_int("coalesce_rises", rises, 1);
    chk_int("coalesce_delivered", nf, 1);

    // Press event coincident with tick
    repeat (2 * P) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 2 * P; k++) begin
      cyc((k >= P - 3 - D) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (k == P - 1) begin
        chk_bit("simul_tick", o_tick, 1'b1);
        chk_bit("simul_flap_in_tick", o_flap, 1'b0);
      end
      if (k == P) chk_bit("simul_flap_after", o_flap, 1'b1);
      if (k == 2 * P - 1) chk_bit("simul_flap_next_tick", o_flap, 1'b1);
      if (k == 2 * P) chk_bit("simul_flap_consumed", o_flap, AUTO);
    end

    // Held button over five tick periods
    repeat (2 * P) cyc(1'b1, 1'b1, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 4 * P && !got; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      got = o_flap;
    end
    chk_bit("hold_flap_seen", got, 1'b1);
    nt = (o_tick) ? 1 : 0;
    nf = (o_tick && o_flap) ? 1 : 0;
    for (int k = 0; k < 6 * P && nt < 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (o_tick) begin
        nt++;
        if (o_flap) nf++;
      end
    end
    chk_int("hold_ticks", nt, 5);
    chk_int("hold_flaps", nf, AUTO ? 5 : 1);

    // Randomized activity
    kv = 1'b1; sgv = 1'b1; hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        kv = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 2 * D + 3);
      end
      hold--;
      if ($urandom_range(0, 149) == 0) sgv = ~sgv;
      cyc(kv, sgv, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
